// File: rtl/w5300_bus_seq.sv
// W5300 direct-mode bus sequencer: turns single read/write requests into timed
// CS/RD/WR cycles and owns the chip's hardware reset pulse and lock-time wait.
module w5300_bus_seq #(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 3,
    parameter int HOLD_CYC     = 1,
    parameter int RST_LOW_CYC  = 64,
    parameter int RST_WAIT_CYC = 65535,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_i,
    input  logic       req_wr_i,
    input  logic [9:0] req_addr_i,
    input  logic [7:0] req_wdata_i,
    input  logic       a0inv_i,
    input  logic       sw_rst_n_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       ready_o,
    output logic       w_cs_n_o,
    output logic       w_rd_n_o,
    output logic       w_wr_n_o,
    output logic [9:0] w_addr_o,
    output logic [7:0] w_dout_o,
    output logic       w_doe_o,
    input  logic [7:0] w_din_i,
    output logic       w_rst_n_o
);

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_IDLE     = 3'd2,
        ST_SETUP    = 3'd3,
        ST_STROBE   = 3'd4,
        ST_HOLD     = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [9:0]       addr_q, addr_d;
    logic [7:0]       dout_q, dout_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             cs_n_q, cs_n_d;
    logic             rd_n_q, rd_n_d;
    logic             wr_n_q, wr_n_d;
    logic             doe_q, doe_d;
    logic             wrst_n_q, wrst_n_d;
    logic             bus_s;

    // Next-state logic; pin values are derived from the next state so every output is a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;

        if (!sw_rst_n_i && (state_q != ST_RST_HOLD)) begin
            // Abort whatever is running; the reset pulse restarts its count.
            state_d = ST_RST_HOLD;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_RST_HOLD: begin
                    if (sw_rst_n_i && (cnt_q >= RST_LAST)) begin
                        state_d = ST_RST_WAIT;
                        cnt_d   = {CNT_W{1'b0}};
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_RST_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (req_i) begin
                        state_d = ST_SETUP;
                        cnt_d   = {CNT_W{1'b0}};
                        wr_d    = req_wr_i;
                        addr_d  = {req_addr_i[9:1], req_addr_i[0] ^ a0inv_i};
                        dout_d  = req_wdata_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        state_d = ST_STROBE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    if (cnt_q == STROBE_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = {CNT_W{1'b0}};
                        if (!wr_q) begin
                            rdata_d = w_din_i;
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RST_HOLD;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end

        bus_s    = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        cs_n_d   = !bus_s;
        rd_n_d   = !((state_d == ST_STROBE) && !wr_d);
        wr_n_d   = !((state_d == ST_STROBE) && wr_d);
        doe_d    = bus_s && wr_d;
        busy_d   = (state_d != ST_IDLE);
        ready_d  = (state_d == ST_IDLE) || bus_s;
        wrst_n_d = (state_d != ST_RST_HOLD);
    end

    // State, counter and registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RST_HOLD;
            cnt_q    <= {CNT_W{1'b0}};
            wr_q     <= 1'b0;
            addr_q   <= 10'd0;
            dout_q   <= 8'd0;
            rdata_q  <= 8'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            doe_q    <= 1'b0;
            wrst_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            doe_q    <= doe_d;
            wrst_n_q <= wrst_n_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rdata_o   = rdata_q;
    assign ready_o   = ready_q;
    assign w_cs_n_o  = cs_n_q;
    assign w_rd_n_o  = rd_n_q;
    assign w_wr_n_o  = wr_n_q;
    assign w_addr_o  = addr_q;
    assign w_dout_o  = dout_q;
    assign w_doe_o   = doe_q;
    assign w_rst_n_o = wrst_n_q;

endmodule

// File: tb/tb_w5300_bus_seq.sv
// Directed bench for w5300_bus_seq: per-cycle vector table for bus accesses plus
// hand-written reset, lock-time and abort sequences.
module tb_w5300_bus_seq;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       req_wr;
    logic [9:0] req_addr;
    logic [7:0] req_wdata;
    logic       a0inv;
    logic       sw_rst_n;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       ready;
    logic       w_cs_n;
    logic       w_rd_n;
    logic       w_wr_n;
    logic [9:0] w_addr;
    logic [7:0] w_dout;
    logic       w_doe;
    logic [7:0] w_din;
    logic       w_rst_n;

    int checks = 0;
    int errors = 0;

    w5300_bus_seq #(
        .RST_LOW_CYC (4),
        .RST_WAIT_CYC(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .req_wr_i   (req_wr),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .a0inv_i    (a0inv),
        .sw_rst_n_i (sw_rst_n),
        .busy_o     (busy),
        .done_o     (done),
        .rdata_o    (rdata),
        .ready_o    (ready),
        .w_cs_n_o   (w_cs_n),
        .w_rd_n_o   (w_rd_n),
        .w_wr_n_o   (w_wr_n),
        .w_addr_o   (w_addr),
        .w_dout_o   (w_dout),
        .w_doe_o    (w_doe),
        .w_din_i    (w_din),
        .w_rst_n_o  (w_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic       wr;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic       a0inv;
        logic [7:0] din;
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       doe;
        logic [9:0] e_addr;
        logic [7:0] e_dout;
        logic       done;
        logic       busy;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rq, input logic wr, input logic [9:0] ad,
                           input logic [7:0] wd, input logic a0, input logic [7:0] di,
                           input logic cs, input logic rd, input logic wn, input logic oe,
                           input logic [9:0] ea, input logic [7:0] ed, input logic dn,
                           input logic by, input logic [7:0] rdv);
        vec_t v;
        v.req = rq; v.wr = wr; v.addr = ad; v.wdata = wd; v.a0inv = a0; v.din = di;
        v.cs_n = cs; v.rd_n = rd; v.wr_n = wn; v.doe = oe; v.e_addr = ea;
        v.e_dout = ed; v.done = dn; v.busy = by; v.rdata = rdv;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cnt;
        int wait_cnt;

        rst_n = 1'b0; req = 1'b0; req_wr = 1'b0; req_addr = 10'd0; req_wdata = 8'd0;
        a0inv = 1'b0; sw_rst_n = 1'b0; w_din = 8'd0;

        // write 0x2A5 / 0x5C
        add_vec(1'b1, 1'b1, 10'h2A5, 8'h5C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 10'h2A5, 8'h5C, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++)
            add_vec(1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 10'h2A5, 8'h5C, 1'b0, 1'b1, 8'h00);
        add_vec(1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 10'h2A5, 8'h5C, 1'b0, 1'b1, 8'h00);
        add_vec(1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 10'h2A5, 8'h5C, 1'b1, 1'b0, 8'h00);
        add_vec(1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 10'h2A5, 8'h5C, 1'b0, 1'b0, 8'h00);
        // read 0x100 with a0inv -> 0x101; din only valid at the final strobe edge
        add_vec(1'b1, 1'b0, 10'h100, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 10'h101, 8'h00, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++)
            add_vec(1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 10'h101, 8'h00, 1'b0, 1'b1, 8'h00);
        add_vec(1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'hA7, 1'b0, 1'b1, 1'b1, 1'b0, 10'h101, 8'h00, 1'b0, 1'b1, 8'hA7);
        add_vec(1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 10'h101, 8'h00, 1'b1, 1'b0, 8'hA7);
        add_vec(1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 10'h101, 8'h00, 1'b0, 1'b0, 8'hA7);
        // three back-to-back writes with req held high
        for (int a = 0; a < 3; a++) begin
            add_vec(1'b1, 1'b1, 10'h00F, 8'hC3, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 10'h00E, 8'hC3, 1'b0, 1'b1, 8'hA7);
            for (int i = 0; i < 3; i++)
                add_vec(1'b1, 1'b1, 10'h00F, 8'hC3, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 10'h00E, 8'hC3, 1'b0, 1'b1, 8'hA7);
            add_vec(1'b1, 1'b1, 10'h00F, 8'hC3, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 10'h00E, 8'hC3, 1'b0, 1'b1, 8'hA7);
            add_vec(1'b1, 1'b1, 10'h00F, 8'hC3, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 10'h00E, 8'hC3, 1'b1, 1'b0, 8'hA7);
        end
        add_vec(1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 10'h00E, 8'hC3, 1'b0, 1'b0, 8'hA7);

        // reset values
        step();
        step();
        chk("rst_cs_n", 32'(w_cs_n), 32'd1);
        chk("rst_rd_n", 32'(w_rd_n), 32'd1);
        chk("rst_wr_n", 32'(w_wr_n), 32'd1);
        chk("rst_doe", 32'(w_doe), 32'd0);
        chk("rst_addr", 32'(w_addr), 32'd0);
        chk("rst_dout", 32'(w_dout), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_w_rst_n", 32'(w_rst_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // chip stays in reset while sw_rst_n=0
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_w_rst_n", 32'(w_rst_n), 32'd0);
            chk("hold_ready", 32'(ready), 32'd0);
        end

        // release; req during lock wait must be ignored
        sw_rst_n = 1'b1;
        step();
        chk("rel_w_rst_n", 32'(w_rst_n), 32'd1);
        chk("rel_ready", 32'(ready), 32'd0);
        req = 1'b1; req_wr = 1'b1; req_addr = 10'h155; req_wdata = 8'hAA;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("wait_ready", 32'(ready), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_cs_n", 32'(w_cs_n), 32'd1);
            chk("wait_wr_n", 32'(w_wr_n), 32'd1);
            chk("wait_done", 32'(done), 32'd0);
        end
        req = 1'b0;
        step();
        chk("lock_ready", 32'(ready), 32'd1);
        chk("lock_busy", 32'(busy), 32'd0);
        chk("lock_cs_n", 32'(w_cs_n), 32'd1);

        // table-driven accesses
        for (int k = 0; k < vecs.size(); k++) begin
            req = vecs[k].req; req_wr = vecs[k].wr; req_addr = vecs[k].addr;
            req_wdata = vecs[k].wdata; a0inv = vecs[k].a0inv; w_din = vecs[k].din;
            step();
            chk($sformatf("v%0d_cs_n", k), 32'(w_cs_n), 32'(vecs[k].cs_n));
            chk($sformatf("v%0d_rd_n", k), 32'(w_rd_n), 32'(vecs[k].rd_n));
            chk($sformatf("v%0d_wr_n", k), 32'(w_wr_n), 32'(vecs[k].wr_n));
            chk($sformatf("v%0d_doe", k), 32'(w_doe), 32'(vecs[k].doe));
            chk($sformatf("v%0d_addr", k), 32'(w_addr), 32'(vecs[k].e_addr));
            chk($sformatf("v%0d_dout", k), 32'(w_dout), 32'(vecs[k].e_dout));
            chk($sformatf("v%0d_done", k), 32'(done), 32'(vecs[k].done));
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].busy));
            chk($sformatf("v%0d_rdata", k), 32'(rdata), 32'(vecs[k].rdata));
            chk($sformatf("v%0d_ready", k), 32'(ready), 32'd1);
        end

        // abort a write in STROBE with a one-cycle sw_rst_n low pulse
        req = 1'b1; req_wr = 1'b1; req_addr = 10'h3C0; req_wdata = 8'h99; a0inv = 1'b0;
        step();
        req = 1'b0;
        step();
        chk("ab_pre_wr_n", 32'(w_wr_n), 32'd0);
        sw_rst_n = 1'b0;
        step();
        sw_rst_n = 1'b1;
        chk("ab_wr_n", 32'(w_wr_n), 32'd1);
        chk("ab_cs_n", 32'(w_cs_n), 32'd1);
        chk("ab_doe", 32'(w_doe), 32'd0);
        chk("ab_w_rst_n", 32'(w_rst_n), 32'd0);
        chk("ab_ready", 32'(ready), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_busy", 32'(busy), 32'd1);
        chk("ab_rdata", 32'(rdata), 32'hA7);

        low_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("ab_no_done", 32'(done), 32'd0);
            if (w_rst_n == 1'b1) break;
            low_cnt++;
        end
        chk("pulse_low_cycles", 32'(low_cnt), 32'd4);

        wait_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (ready == 1'b1) break;
            step();
            wait_cnt++;
        end
        chk("pulse_lock_cycles", 32'(wait_cnt), 32'd8);
        chk("post_rdata", 32'(rdata), 32'hA7);
        chk("post_cs_n", 32'(w_cs_n), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
